// File: rtl/bus_copy_pkg.sv
// Shared types and constants for the word-copy bus master.
package bus_copy_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_REQ,
      WR_WAIT,
      DONE
   } copy_state_e;

   localparam int unsigned WORD_BYTES = 4;
   localparam logic [3:0]  BE_FULL    = 4'hF;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/bus_if.sv
// Single-outstanding req/gnt/rvalid bus between an initiator and a slave.
interface bus_if;

   logic        req;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        gnt;
   logic [31:0] rdata;
   logic        rvalid;
   logic        err;

   modport master (
      output req, addr, we, be, wdata,
      input  gnt, rdata, rvalid, err
   );

   modport slave (
      input  req, addr, we, be, wdata,
      output gnt, rdata, rvalid, err
   );

endinterface

// File: rtl/bus_copy_master.sv
// Word-copy engine: reads len words from src and writes them to dst,
// one bus transaction outstanding at a time.
module bus_copy_master
   import bus_copy_pkg::*;
#(
   parameter int LEN_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [31:0]      src_addr_i,
   input  logic [31:0]      dst_addr_i,
   input  logic [LEN_W-1:0] len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   bus_if.master            bus
);

   copy_state_e      state_q;
   logic [31:0]      src_q;
   logic [31:0]      dst_q;
   logic [31:0]      src_d;
   logic [31:0]      dst_d;
   logic [LEN_W-1:0] rem_q;
   logic [31:0]      data_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;
   logic             req_q;
   logic             we_q;
   logic [3:0]       be_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;

   assign src_d = src_q + 32'(WORD_BYTES);
   assign dst_d = dst_q + 32'(WORD_BYTES);

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign err_o     = err_q;
   assign bus.req   = req_q;
   assign bus.we    = we_q;
   assign bus.be    = be_q;
   assign bus.addr  = addr_q;
   assign bus.wdata = wdata_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         be_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  src_q <= word_align(src_addr_i);
                  dst_q <= word_align(dst_addr_i);
                  rem_q <= len_i;
                  err_q <= 1'b0;
                  if (len_i != '0) begin
                     state_q <= RD_REQ;
                     busy_q  <= 1'b1;
                     req_q   <= 1'b1;
                     we_q    <= 1'b0;
                     be_q    <= BE_FULL;
                     addr_q  <= word_align(src_addr_i);
                  end else begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            RD_REQ: begin
               if (bus.gnt) begin
                  req_q   <= 1'b0;
                  state_q <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (bus.rvalid) begin
                  data_q <= bus.rdata;
                  if (bus.err) begin
                     err_q   <= 1'b1;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     req_q   <= 1'b1;
                     we_q    <= 1'b1;
                     be_q    <= BE_FULL;
                     addr_q  <= dst_q;
                     wdata_q <= bus.rdata;
                     state_q <= WR_REQ;
                  end
               end
            end
            WR_REQ: begin
               if (bus.gnt) begin
                  req_q   <= 1'b0;
                  state_q <= WR_WAIT;
               end
            end
            WR_WAIT: begin
               if (bus.rvalid) begin
                  if (bus.err) begin
                     err_q   <= 1'b1;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     src_q <= src_d;
                     dst_q <= dst_d;
                     rem_q <= rem_q - LEN_W'(1);
                     // Last word written: finish instead of issuing another read
                     if (rem_q == LEN_W'(1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                     end else begin
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        be_q    <= BE_FULL;
                        addr_q  <= src_d;
                        state_q <= RD_REQ;
                     end
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_copy_master.sv
// Directed bench for bus_copy_master with a word-addressed memory slave
// that supports grant stalls and read error injection.
module tb_bus_copy_master;

   logic        clk_i      = 1'b0;
   logic        rst_ni     = 1'b0;
   logic        start_i    = 1'b0;
   logic [31:0] src_addr_i = '0;
   logic [31:0] dst_addr_i = '0;
   logic [15:0] len_i      = '0;
   logic        busy_o;
   logic        done_o;
   logic        err_o;

   bus_if bus ();

   bus_copy_master #(.LEN_W(16)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .start_i    (start_i),
      .src_addr_i (src_addr_i),
      .dst_addr_i (dst_addr_i),
      .len_i      (len_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_o      (err_o),
      .bus        (bus)
   );

   always #5 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem [0:8191];
   int rd_cnt     = 0;
   int wr_cnt     = 0;
   int err_rd     = -1;
   int req_cnt    = 0;
   int stall_sum  = 0;
   int stall_q    = 0;
   int cur_len    = 0;
   bit rand_stall = 1'b0;

   assign bus.gnt = bus.req && (stall_q == 0);

   always @(posedge clk_i) begin
      bus.rvalid <= 1'b0;
      bus.err    <= 1'b0;
      if (bus.req) req_cnt++;
      if (bus.req && bus.gnt) begin
         bus.rvalid <= 1'b1;
         stall_sum += cur_len;
         cur_len = rand_stall ? int'($urandom_range(3, 0)) : 0;
         stall_q <= cur_len;
         if (bus.we) begin
            mem[bus.addr[14:2]] <= bus.wdata;
            wr_cnt++;
         end else begin
            rd_cnt++;
            bus.rdata <= mem[bus.addr[14:2]];
            bus.err   <= (rd_cnt == err_rd);
         end
      end else if (bus.req && stall_q != 0) begin
         stall_q <= stall_q - 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Request must hold addr/we/wdata while waiting for a grant
   logic        hv;
   logic [31:0] ha;
   logic [31:0] hw;
   logic        hwe;
   always @(posedge clk_i) begin
      hv  <= bus.req && !bus.gnt && rst_ni;
      ha  <= bus.addr;
      hw  <= bus.wdata;
      hwe <= bus.we;
   end
   always @(negedge clk_i) begin
      if (hv && bus.req && rst_ni) begin
         chk("stable_addr", bus.addr, ha);
         chk("stable_we", {31'b0, bus.we}, {31'b0, hwe});
         if (bus.we) chk("stable_wdata", bus.wdata, hw);
      end
   end

   task automatic run(input logic [31:0] s, input logic [31:0] d, input int l,
                      input int poke, output int n, output logic b1,
                      output logic dn, output logic bend);
      @(negedge clk_i);
      src_addr_i = s;
      dst_addr_i = d;
      len_i      = 16'(l);
      start_i    = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      n  = 1;
      b1 = busy_o;
      while (!done_o && n < 2000) begin
         if (n == poke) begin
            start_i    = 1'b1;
            src_addr_i = 32'h100;
            len_i      = 16'd1;
         end
         @(negedge clk_i);
         start_i = 1'b0;
         n++;
      end
      dn   = done_o;
      bend = busy_o;
   endtask

   initial begin
      int n;
      int r0;
      int w0;
      int s0;
      int t;
      logic b1;
      logic dn;
      logic bend;

      for (int i = 0; i < 8192; i++) mem[i] = '0;
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
      for (int i = 0; i < 16; i++) mem[32'h800 + i] = 32'hBEEF_0000 + 32'(i * 7);
      for (int i = 0; i < 5; i++)  mem[32'h40 + i]  = 32'hA0 + 32'(i);
      for (int i = 0; i < 4; i++)  mem[32'h60 + i]  = 32'hC0 + 32'(i);
      for (int i = 0; i < 3; i++)  mem[32'h80 + i]  = 32'hD0 + 32'(i);

      #12;
      chk("rst_busy", {31'b0, busy_o}, 32'd0);
      chk("rst_done", {31'b0, done_o}, 32'd0);
      chk("rst_err", {31'b0, err_o}, 32'd0);
      chk("rst_req", {31'b0, bus.req}, 32'd0);
      chk("rst_we", {31'b0, bus.we}, 32'd0);
      chk("rst_be", {28'b0, bus.be}, 32'd0);
      chk("rst_addr", bus.addr, 32'd0);
      chk("rst_wdata", bus.wdata, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // 4-word copy, zero-wait slave
      run(32'h0000, 32'h4000, 4, -1, n, b1, dn, bend);
      chk("c4_cycles", 32'(n), 32'd17);
      chk("c4_done", {31'b0, dn}, 32'd1);
      chk("c4_busy_first", {31'b0, b1}, 32'd1);
      chk("c4_busy_at_done", {31'b0, bend}, 32'd0);
      chk("c4_err", {31'b0, err_o}, 32'd0);
      for (int i = 0; i < 4; i++) chk("c4_data", mem[32'h1000 + i], 32'h11 * 32'(i + 1));
      @(negedge clk_i);
      chk("c4_done_pulse", {31'b0, done_o}, 32'd0);

      // 16-word copy with random grant stalls
      rand_stall = 1'b1;
      s0 = stall_sum;
      run(32'h2000, 32'h6800, 16, -1, n, b1, dn, bend);
      rand_stall = 1'b0;
      chk("c16_cycles", 32'(n), 32'(65 + stall_sum - s0));
      chk("c16_done", {31'b0, dn}, 32'd1);
      for (int i = 0; i < 16; i++)
         chk("c16_data", mem[32'h1A00 + i], 32'hBEEF_0000 + 32'(i * 7));

      // read error on third word of a 5-word copy
      err_rd = rd_cnt + 3;
      w0 = wr_cnt;
      run(32'h0100, 32'h4800, 5, -1, n, b1, dn, bend);
      err_rd = -1;
      chk("err_done", {31'b0, dn}, 32'd1);
      chk("err_flag", {31'b0, err_o}, 32'd1);
      chk("err_busy", {31'b0, bend}, 32'd0);
      chk("err_writes", 32'(wr_cnt - w0), 32'd2);
      chk("err_w0", mem[32'h1200], 32'hA0);
      chk("err_w1", mem[32'h1201], 32'hA1);
      chk("err_w2", mem[32'h1202], 32'h0);
      @(negedge clk_i);
      chk("err_sticky", {31'b0, err_o}, 32'd1);

      // zero-length start: immediate done, clears err, no bus traffic
      r0 = req_cnt;
      run(32'h0000, 32'h7000, 0, -1, n, b1, dn, bend);
      chk("len0_cycles", 32'(n), 32'd1);
      chk("len0_done", {31'b0, dn}, 32'd1);
      chk("len0_err_clr", {31'b0, err_o}, 32'd0);
      chk("len0_busy", {31'b0, b1}, 32'd0);
      repeat (3) @(negedge clk_i);
      chk("len0_no_req", 32'(req_cnt - r0), 32'd0);

      // reset during WR_REQ of word 2
      @(negedge clk_i);
      src_addr_i = 32'h180;
      dst_addr_i = 32'h5000;
      len_i      = 16'd4;
      start_i    = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      t = 0;
      while (!(bus.req && bus.we && bus.addr == 32'h5004) && t < 100) begin
         @(negedge clk_i);
         t++;
      end
      chk("rst_reach_wr2", 32'(t < 100), 32'd1);
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_req", {31'b0, bus.req}, 32'd0);
      chk("mid_rst_busy", {31'b0, busy_o}, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("post_rst_req", {31'b0, bus.req}, 32'd0);
      chk("rst_w0", mem[32'h1400], 32'hC0);
      chk("rst_w1", mem[32'h1401], 32'h0);
      run(32'h0203, 32'h6001, 3, -1, n, b1, dn, bend);
      chk("post_rst_cycles", 32'(n), 32'd13);
      for (int i = 0; i < 3; i++) chk("post_rst_data", mem[32'h1800 + i], 32'hD0 + 32'(i));

      // start while busy is ignored
      run(32'h0000, 32'h4400, 3, 3, n, b1, dn, bend);
      chk("busy_start_cycles", 32'(n), 32'd13);
      for (int i = 0; i < 3; i++) chk("busy_start_data", mem[32'h1100 + i], 32'h11 * 32'(i + 1));
      chk("busy_start_extra", mem[32'h1103], 32'h0);
      repeat (3) @(negedge clk_i);
      chk("busy_start_idle", {31'b0, busy_o}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bus_copy_master.md
# bus_copy_master

Single-channel word-copy engine and bus initiator. It drives the master end of `bus_if` (req/gnt/rvalid/err), reads `len` consecutive 32-bit words starting at a source address, and writes them to a destination address. A sequencer programs it through a start/done handshake. It sits beside the core's data port and targets the data RAM bank and other `bus_if` slaves.

## Interface
Parameters:
- `LEN_W`, 16: width of the word-count input; the maximum transfer is 2^LEN_W − 1 words.

Ports:
- `clk_i`, input, 1: sole clock, rising edge.
- `rst_ni`, input, 1: reset, asynchronous, active-low.
- `start_i`, input, 1: launch request, sampled when idle.
- `src_addr_i`, input, 32: source byte address; bits [1:0] are ignored (forced to 0).
- `dst_addr_i`, input, 32: destination byte address; bits [1:0] are ignored.
- `len_i`, input, LEN_W: number of words to copy.
- `busy_o`, output, 1: high from the cycle after an accepted start until `done_o`.
- `done_o`, output, 1: single-cycle pulse when the transfer ends, whether it ends normally or by abort.
- `err_o`, output, 1: sticky error flag; cleared by the next accepted start.
- `bus`, `bus_if.master`: drives req/addr/we/be/wdata; samples gnt/rdata/rvalid/err.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
- IDLE: `start_i`=1 latches src, dst and len into internal counters and clears `err_o`.
  - If len≠0, the next state is RD_REQ.
  - If len=0, the next state is DONE, with no bus traffic.
  - `start_i` is ignored in every state other than IDLE.
- RD_REQ: drive req=1, we=0, be=4'hF, addr=src_q. These signals are held stable until gnt=1; on gnt the next state is RD_WAIT.
- RD_WAIT: req=0. On rvalid, capture rdata into a 32-bit data register.
  - err=1 with rvalid: set `err_o` and go to DONE (abort).
  - Otherwise go to WR_REQ.
- WR_REQ: req=1, we=1, be=4'hF, addr=dst_q, wdata=data register. Held stable until gnt; then go to WR_WAIT.
- WR_WAIT: wait for rvalid; every write also returns rvalid.
  - err=1: set `err_o` and go to DONE.
  - Otherwise: src_q += 4, dst_q += 4, remaining −= 1.
  - If remaining was 1, go to DONE; else go to RD_REQ.
- DONE: `done_o`=1 for one cycle, then go to IDLE.
- Address arithmetic: 32-bit unsigned and wraps modulo 2^32, with no boundary check. Overlapping regions are copied in ascending order, with no overlap protection.
- Only one transaction is outstanding at a time. req is never asserted while a response is pending.
- rvalid or gnt arriving in a state that does not expect it is ignored.
- Reset mid-transfer: all state returns to IDLE immediately and req drops asynchronously. The slave may still return rvalid once after reset, and the block ignores it.

## Timing
- Reset values:
  - busy_o=0, done_o=0, err_o=0.
  - bus.req=0, bus.we=0, bus.be=0, bus.addr=0, bus.wdata=0.
  - Counters and data register = 0.
- Start accepted at rising edge k: state is RD_REQ and busy_o=1 during cycle k+1.
- Per word against a slave with same-cycle gnt and rvalid one cycle later: exactly 4 cycles (RD_REQ, RD_WAIT, WR_REQ, WR_WAIT).
- An N-word copy has done_o in cycle k+1+4N, and busy_o falls in the same cycle that done_o rises.
- len=0: done_o in cycle k+1.
- gnt stalls of S cycles add S cycles per request. rvalid latency L adds L−1 cycles per response.
- done_o and start_i on the same cycle: the start is ignored (state is DONE, not IDLE). A start in the next cycle is accepted.

## Structure
- `bus_copy_pkg`: state enum `copy_state_e`, constant `WORD_BYTES`=4, and the full-word byte-enable constant.
- One module with no sub-modules. The FSM, the three counters and the data register are all local.

## Test plan
- Copy 4 words: mem[0x0000..0x000C]=0x11,0x22,0x33,0x44; src=0x0000, dst=0x4000 (bank 1). Required: mem[0x4000..0x400C] matches, done_o at cycle k+17, err_o=0.
- len=0 with start: done_o one cycle later, and no req asserted at any time.
- Random gnt stall of 0–3 cycles per request on a 16-word copy. Required: addr/we/wdata stable while req=1 & gnt=0, data is correct, and the cycle count is 4·16+1 plus the total stall cycles.
- Slave returns err on the 3rd read of a 5-word copy. Required: err_o=1, done_o pulses, only 2 words are written, and the next start clears err_o.
- rst_ni asserted in WR_REQ of word 2. Required: req=0 immediately, busy_o=0, and the next start copies correctly from its new addresses.
- start_i pulsed while busy with a different src: ignored, and the original transfer completes unchanged.
